// File: rtl/fir_avg_pkg.sv
// Shared definitions for the 4-tap averaging FIR sequencer.
//   fir_state_t : sequencer states, one adder slot per state
//   TAPS        : number of filter taps
//   acc_w()     : accumulator width for a given sample width (sum of 4 never overflows)
package fir_avg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISS01,
    ISS23,
    CAP01,
    ISSF,
    WAITF,
    LOADF,
    OUTV
  } fir_state_t;

  localparam int TAPS = 4;

  function automatic int acc_w(input int size);
    return size + 2;
  endfunction

endpackage

// File: rtl/addergen1_top.sv
// Registered ripple-carry adder, no reset.
// Operands are registered on one edge and the sum on the next, so a result
// appears on sum/co two edges after a/b/ci are driven.
//   clk  : rising-edge clock
//   a, b : SIZE-bit operands
//   ci   : carry in
//   sum  : registered SIZE-bit sum
//   co   : registered carry out
module addergen1_top #(
  parameter int SIZE = 18
) (
  input  logic            clk,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] sum,
  output logic            co
);

  logic [SIZE-1:0] a_r;
  logic [SIZE-1:0] b_r;
  logic            ci_r;
  logic [SIZE-1:0] sum_nxt;
  logic            co_nxt;

  always_ff @(posedge clk) begin
    a_r  <= a;
    b_r  <= b;
    ci_r <= ci;
  end

  always_comb begin
    logic c;
    c       = ci_r;
    sum_nxt = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      sum_nxt[i] = a_r[i] ^ b_r[i] ^ c;
      c          = (a_r[i] & b_r[i]) | (c & (a_r[i] ^ b_r[i]));
    end
    co_nxt = c;
  end

  always_ff @(posedge clk) begin
    sum <= sum_nxt;
    co  <= co_nxt;
  end

endmodule

// File: rtl/fir_avg_seq.sv
// Sequencer for the 4-tap unsigned averaging FIR: out = floor((x0+x1+x2+x3)/4),
// computed by time-sharing a single registered adder.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   in_valid   : sample present on in_data
//   in_ready   : sequencer can accept a sample (IDLE and no clr)
//   in_data    : new sample x0
//   clr        : zero the tap history, honoured only in IDLE
//   out_valid  : out_data holds a new average
//   out_ready  : consumer takes out_data
//   out_data   : floor of the 4-tap average
module fir_avg_seq
  import fir_avg_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int ACC_W = acc_w(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic            clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data
);

  fir_state_t       state;
  logic [SIZE-1:0]  taps [TAPS];
  logic [ACC_W-1:0] s01;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] sum;
  logic             adder_co_unused;

  assign in_ready = (state == IDLE) && !clr;

  // Operand schedule. CAP01 keeps x2/x3 on the adder so that the sum register
  // still reads x2+x3 during WAITF; that keeps b=sum constant across ISSF and
  // WAITF without a separate holding register for the second partial sum.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      ISS01: begin
        add_a = ACC_W'(taps[0]);
        add_b = ACC_W'(taps[1]);
      end
      ISS23, CAP01: begin
        add_a = ACC_W'(taps[2]);
        add_b = ACC_W'(taps[3]);
      end
      ISSF, WAITF: begin
        add_a = s01;
        add_b = sum;
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  addergen1_top #(.SIZE(ACC_W)) u_adder (
    .clk (clk),
    .a   (add_a),
    .b   (add_b),
    .ci  (1'b0),
    .sum (sum),
    .co  (adder_co_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      s01       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned i = 0; i < TAPS; i++) taps[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            for (int unsigned i = 0; i < TAPS; i++) taps[i] <= '0;
          end else if (in_valid) begin
            for (int unsigned i = TAPS - 1; i > 0; i--) taps[i] <= taps[i-1];
            taps[0] <= in_data;
            state   <= ISS01;
          end
        end
        ISS01: state <= ISS23;
        ISS23: state <= CAP01;
        CAP01: begin
          s01   <= sum;
          state <= ISSF;
        end
        ISSF:  state <= WAITF;
        WAITF: state <= LOADF;
        LOADF: begin
          out_data  <= sum[ACC_W-1:2];
          out_valid <= 1'b1;
          state     <= OUTV;
        end
        OUTV: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_avg_seq.sv
// Bench for fir_avg_seq (SIZE=16): directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// sample-history / latency model of the filter.
module tb_fir_avg_seq;

  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            clr = 1'b0;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] in_data = '0;
  logic            in_ready;
  logic            out_valid;
  logic [SIZE-1:0] out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_avg_seq #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference model: last four accepted samples, a busy period of 6 edges
  // after each accept, then the average is held until the consumer takes it.
  int unsigned     hist [4];
  bit              m_live = 0;
  bit              m_busy = 0;
  bit              m_hold = 0;
  int              m_cnt = 0;
  int              m_accepts = 0;
  logic [SIZE-1:0] m_pend = '0;
  logic [SIZE-1:0] m_data = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      hist   = '{default: 0};
      m_busy = 0;
      m_hold = 0;
      m_cnt  = 0;
      m_data = '0;
      m_live = 1;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 6) begin
        m_busy = 0;
        m_hold = 1;
        m_data = m_pend;
      end
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (clr) begin
      hist = '{default: 0};
    end else if (in_valid) begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(in_data);
      m_pend  = SIZE'((hist[0] + hist[1] + hist[2] + hist[3]) / 4);
      m_busy  = 1;
      m_cnt   = 0;
      m_accepts++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", longint'(in_ready), longint'(!m_busy && !m_hold && !clr));
      check("out_valid", longint'(out_valid), longint'(m_hold));
      check("out_data", longint'(out_data), longint'(m_data));
      if (m_busy && m_cnt >= 2) check("adder_co", longint'(dut.u_adder.co), 0);
    end
  end

  // Present a sample until the model reports it accepted (bounded).
  task automatic send(input logic [SIZE-1:0] v);
    int start;
    start    = m_accepts;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 40 && m_accepts == start; i++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (m_accepts == start) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: sample %0h not accepted within 40 clocks", v);
    end
  endtask

  // Wait for out_valid (bounded), compare out_data with a literal, then step
  // to the next edge (which is the handshake edge when out_ready is high).
  task automatic wait_out(input string name, input logic [SIZE-1:0] exp, output int edges);
    int n;
    n     = 0;
    edges = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 30);
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: out_valid not seen within 30 clocks", name);
    end else begin
      edges = n - 1;
      check(name, longint'(out_data), longint'(exp));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [SIZE-1:0] vals [4];
    logic [SIZE-1:0] exps [4];

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Single sample after reset: latency and value
    out_ready = 1'b1;
    send(16'd100);
    wait_out("first_avg", 16'd25, lat);
    check("first_latency", lat, 6);
    check("model_pin_25", longint'(m_data), 25);

    // Ramp from reset
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    vals = '{16'd4, 16'd8, 16'd12, 16'd16};
    exps = '{16'd1, 16'd3, 16'd6, 16'd10};
    for (int i = 0; i < 4; i++) begin
      send(vals[i]);
      wait_out("ramp", exps[i], lat);
    end
    check("model_pin_10", longint'(m_data), 10);

    // Full-scale samples, history 16,12,8 still present for the first three
    exps = '{16'd16392, 16'd32774, 16'd49155, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      send(16'hFFFF);
      wait_out("full_scale", exps[i], lat);
    end

    // clr in IDLE wipes history
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    send(16'd8);
    wait_out("after_clr", 16'd2, lat);

    // clr during ISS23 is ignored
    send(16'd4);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    wait_out("clr_ignored_busy", 16'd3, lat);

    // clr together with in_valid in IDLE: clr wins, sample taken next cycle
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd12;
    @(negedge clk);
    check("clr_blocks_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1 clr = 1'b0;
    send(16'd12);
    wait_out("clr_and_valid", 16'd3, lat);

    // Back-pressure for 10 clocks with in_valid held
    out_ready = 1'b0;
    send(16'd20);
    wait_out("bp_first", 16'd8, lat);
    in_valid = 1'b1;
    in_data  = 16'd24;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("bp_data_stable", longint'(out_data), 8);
    check("bp_valid_held", longint'(out_valid), 1);
    check("bp_in_ready_low", longint'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", longint'(out_valid), 0);
    check("bp_release_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_next_accepted", longint'(in_ready), 0);
    wait_out("bp_next", 16'd14, lat);

    // Reset while in ISSF drops the in-flight result
    send(16'd36);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_pulse_after_reset", longint'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(16'd40);
    wait_out("after_mid_reset", 16'd10, lat);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = 16'hFFFF;
        1:       in_data = 16'(($urandom_range(0, 7)));
        default: in_data = 16'($urandom);
      endcase
      clr       = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      @(posedge clk);
      #1;
    end
    rst_n     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
